// File: rtl/arb_mux_n.sv
// arb_mux_n: N-channel arbitrating mux feeding one registered output beat (fixed priority or round robin).
// Optional packet locking on last_i is compiled in when the macro ARB_MUX_HOLD_EN is defined.
module arb_mux_n #(
  parameter int SIZE = 32,
  parameter int N    = 4,
  parameter int RR   = 0,
  localparam int CW  = $clog2(N)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [N*SIZE-1:0] data_i,
  input  logic [N-1:0]      valid_i,
`ifdef ARB_MUX_HOLD_EN
  input  logic [N-1:0]      last_i,
`endif
  output logic [N-1:0]      ready_o,
  output logic [SIZE-1:0]   data_o,
  output logic [CW-1:0]     chan_o,
  output logic              valid_o,
  input  logic              ready_i
);

  logic            load;
  logic [N-1:0]    req;
  logic [CW-1:0]   ptr;
  logic [CW-1:0]   base;
  logic [CW:0]     cand;
  logic [CW-1:0]   gnt_idx;
  logic            gnt_any;
  logic [CW-1:0]   ptr_next;
  logic [SIZE-1:0] sel_data;

  // The output register can take a new beat when empty or when it drains this cycle.
  assign load = ~valid_o | ready_i;
  assign base = (RR != 0) ? ptr : '0;

`ifdef ARB_MUX_HOLD_EN
  logic          locked;
  logic [CW-1:0] lock_chan;

  // While a packet is in flight only its channel may compete.
  always_comb begin
    req = valid_i;
    if (locked) begin
      req = '0;
      req[lock_chan] = valid_i[lock_chan];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      locked    <= 1'b0;
      lock_chan <= '0;
    end else if (load && gnt_any) begin
      locked    <= ~last_i[gnt_idx];
      lock_chan <= gnt_idx;
    end
  end
`else
  assign req = valid_i;
`endif

  // Search upward from base with wrap; base is zero in fixed-priority mode.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = '0;
    for (int i = 0; i < N; i++) begin
      cand = {1'b0, base} + (CW+1)'(i);
      if (cand >= (CW+1)'(N)) cand = cand - (CW+1)'(N);
      if (!gnt_any && req[cand[CW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = cand[CW-1:0];
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < N; k++) begin
      if (gnt_idx == CW'(k)) sel_data = data_i[k*SIZE +: SIZE];
    end
  end

  assign ptr_next = (gnt_idx == CW'(N-1)) ? '0 : gnt_idx + CW'(1);

  always_comb begin
    ready_o = '0;
    if (!rst_i && load && gnt_any) ready_o[gnt_idx] = 1'b1;
  end

  // Output stage: capture on load, otherwise hold under backpressure.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_o <= 1'b0;
      data_o  <= '0;
      chan_o  <= '0;
      ptr     <= '0;
    end else if (load) begin
      if (gnt_any) begin
        valid_o <= 1'b1;
        data_o  <= sel_data;
        chan_o  <= gnt_idx;
        ptr     <= ptr_next;
      end else begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_arb_mux_n.sv
// Bench for arb_mux_n: fixed-priority and round-robin instances share stimulus and are
// compared every cycle against a queue-free behavioural model, plus directed literal checks.
module tb_arb_mux_n;
  localparam int SIZE = 32;
  localparam int N    = 4;
  localparam int CW   = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [N*SIZE-1:0] data;
  logic [N-1:0]      vld;
  logic              rdy;
`ifdef ARB_MUX_HOLD_EN
  logic [N-1:0]      last = '1;
`endif
  logic [N-1:0]      rdy_o [2];
  logic [SIZE-1:0]   dat_o [2];
  logic [CW-1:0]     chn_o [2];
  logic              vld_o [2];

  logic              m_valid [2];
  logic [SIZE-1:0]   m_data  [2];
  int                m_chan  [2];
  int                m_ptr   [2];
  logic              n_valid [2];
  logic [SIZE-1:0]   n_data  [2];
  int                n_chan  [2];
  int                n_ptr   [2];
  logic              model_on;
  int                passed = 0;
  int                total  = 0;

  always #5 clk = ~clk;

  arb_mux_n #(.SIZE(SIZE), .N(N), .RR(0)) dut_fp (
    .clk_i(clk), .rst_i(rst), .data_i(data), .valid_i(vld),
`ifdef ARB_MUX_HOLD_EN
    .last_i(last),
`endif
    .ready_o(rdy_o[0]), .data_o(dat_o[0]), .chan_o(chn_o[0]), .valid_o(vld_o[0]),
    .ready_i(rdy));

  arb_mux_n #(.SIZE(SIZE), .N(N), .RR(1)) dut_rr (
    .clk_i(clk), .rst_i(rst), .data_i(data), .valid_i(vld),
`ifdef ARB_MUX_HOLD_EN
    .last_i(last),
`endif
    .ready_o(rdy_o[1]), .data_o(dat_o[1]), .chan_o(chn_o[1]), .valid_o(vld_o[1]),
    .ready_i(rdy));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // First requesting channel walking upward from base, wrapping; -1 when nobody requests.
  function automatic int pick(input logic [N-1:0] v, input int base);
    for (int off = 0; off < N; off++) begin
      if (v[(base + off) % N]) return (base + off) % N;
    end
    return -1;
  endfunction

  task automatic set_ch(input int ch, input logic [SIZE-1:0] val);
    data[ch*SIZE +: SIZE] = val;
  endtask

  task automatic sample();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      int           g;
      logic         ld;
      logic [N-1:0] er;
      ld = !m_valid[d] || rdy;
      g  = pick(vld, (d == 1) ? m_ptr[d] : 0);
      er = '0;
      if (!rst && ld && g >= 0) er[g] = 1'b1;
      if (model_on) begin
        chk($sformatf("model ready_o dut%0d", d), 64'(rdy_o[d]), 64'(er));
        chk($sformatf("model valid_o dut%0d", d), 64'(vld_o[d]), 64'(m_valid[d]));
        chk($sformatf("model data_o dut%0d", d), 64'(dat_o[d]), 64'(m_data[d]));
        chk($sformatf("model chan_o dut%0d", d), 64'(chn_o[d]), 64'(m_chan[d]));
      end
      n_valid[d] = m_valid[d];
      n_data[d]  = m_data[d];
      n_chan[d]  = m_chan[d];
      n_ptr[d]   = m_ptr[d];
      if (rst) begin
        n_valid[d] = 1'b0;
        n_data[d]  = '0;
        n_chan[d]  = 0;
        n_ptr[d]   = 0;
      end else if (ld) begin
        if (g >= 0) begin
          n_valid[d] = 1'b1;
          n_data[d]  = data[g*SIZE +: SIZE];
          n_chan[d]  = g;
          n_ptr[d]   = (g + 1) % N;
        end else begin
          n_valid[d] = 1'b0;
        end
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      m_valid[d] = n_valid[d];
      m_data[d]  = n_data[d];
      m_chan[d]  = n_chan[d];
      m_ptr[d]   = n_ptr[d];
    end
  endtask

  task automatic cyc();
    sample();
    advance();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    vld = '0;
    rdy = 1'b0;
    repeat (2) cyc();
    rst = 1'b0;
  endtask

  initial begin
    int seq[5];
    seq = '{0, 1, 2, 3, 0};
    for (int d = 0; d < 2; d++) begin
      m_valid[d] = 1'b0; m_data[d] = '0; m_chan[d] = 0; m_ptr[d] = 0;
    end
    rst = 1'b1; vld = '0; rdy = 1'b0; data = '0;
    model_on = 1'b0;
    cyc();
    model_on = 1'b1;
    do_reset();

    // Reset state
    sample();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset valid_o dut%0d", d), 64'(vld_o[d]), 64'd0);
      chk($sformatf("reset data_o dut%0d", d), 64'(dat_o[d]), 64'd0);
      chk($sformatf("reset chan_o dut%0d", d), 64'(chn_o[d]), 64'd0);
    end
    advance();

    // Fixed priority picks channel 1 out of 0110 every cycle
    for (int c = 0; c < N; c++) set_ch(c, $urandom);
    vld = 4'b0110; rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sample();
      chk("fp ready_o 0110", 64'(rdy_o[0]), 64'h2);
      if (i > 0) chk("fp chan_o 0110", 64'(chn_o[0]), 64'd1);
      advance();
    end

    // Round robin rotation with all channels requesting
    do_reset();
    vld = 4'b1111; rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      sample();
      if (i > 0) chk($sformatf("rr chan_o seq %0d", i), 64'(chn_o[1]), 64'(seq[i-1]));
      advance();
    end

    // Backpressure holds the beat
    do_reset();
    set_ch(0, 32'hA5A5_A5A5);
    vld = 4'b0001; rdy = 1'b1;
    cyc();
    vld = 4'b1111; rdy = 1'b0;
    set_ch(0, 32'h1234_5678);
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("bp data_o", 64'(dat_o[0]), 64'hA5A5_A5A5);
      chk("bp chan_o", 64'(chn_o[0]), 64'd0);
      chk("bp ready_o", 64'(rdy_o[0]), 64'd0);
      chk("bp valid_o", 64'(vld_o[0]), 64'd1);
      advance();
    end
    rdy = 1'b1;
    sample();
    chk("bp release ready_o", 64'(rdy_o[0]), 64'h1);
    advance();
    rdy = 1'b0;
    sample();
    chk("bp next data_o", 64'(dat_o[0]), 64'h1234_5678);
    advance();

    // Round robin wrap from pointer 3
    do_reset();
    rdy = 1'b1;
    vld = 4'b0100;
    cyc();
    vld = 4'b0001;
    sample();
    chk("rr wrap ready_o", 64'(rdy_o[1]), 64'h1);
    advance();
    vld = 4'b0011;
    sample();
    chk("rr wrap chan_o", 64'(chn_o[1]), 64'd0);
    chk("rr ptr1 ready_o", 64'(rdy_o[1]), 64'h2);
    advance();

    // Reset mid-operation discards the held beat
    vld = 4'b1111; rdy = 1'b1;
    cyc();
    rst = 1'b1;
    sample();
    for (int d = 0; d < 2; d++)
      chk($sformatf("rst ready_o dut%0d", d), 64'(rdy_o[d]), 64'd0);
    advance();
    sample();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst valid_o dut%0d", d), 64'(vld_o[d]), 64'd0);
      chk($sformatf("rst data_o dut%0d", d), 64'(dat_o[d]), 64'd0);
      chk($sformatf("rst hold ready_o dut%0d", d), 64'(rdy_o[d]), 64'd0);
    end
    advance();
    rst = 1'b0;

`ifdef ARB_MUX_HOLD_EN
    // Packet lock on channel 2 for three beats
    do_reset();
    model_on = 1'b0;
    rdy = 1'b1;
    vld = 4'b0100; last = 4'b0000;
    cyc();
    vld = 4'b0101;
    sample();
    chk("hold ready_o", 64'(rdy_o[0]), 64'h4);
    for (int d = 0; d < 2; d++) chk("hold chan_o b1", 64'(chn_o[d]), 64'd2);
    advance();
    last = 4'b0100;
    sample();
    for (int d = 0; d < 2; d++) chk("hold chan_o b2", 64'(chn_o[d]), 64'd2);
    advance();
    last = 4'b1111;
    sample();
    for (int d = 0; d < 2; d++) chk("hold chan_o b3", 64'(chn_o[d]), 64'd2);
    chk("hold release ready_o", 64'(rdy_o[0]), 64'h1);
    advance();
    sample();
    for (int d = 0; d < 2; d++) chk("hold next chan_o", 64'(chn_o[d]), 64'd0);
    advance();
    do_reset();
    model_on = 1'b1;
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(39, 0) == 0);
      vld = 4'($urandom_range(15, 0));
      rdy = ($urandom_range(3, 0) != 0);
      for (int c = 0; c < N; c++) set_ch(c, $urandom);
      cyc();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/arb_mux_n.md
ARB_MUX_N -- requirements
Module: arb_mux_n

Interface
REQ-001 SHALL have parameter SIZE, default 32, data width per channel in bits.
REQ-002 SHALL have parameter N, default 4, number of input channels, legal 2..16.
REQ-003 SHALL have parameter RR, default 0, arbitration mode: 0 fixed priority, 1 round robin.
REQ-004 SHALL define CW = $clog2(N), the channel-index width.
REQ-005 SHALL have port clk_i  input  1  clock; all state updates on rising edge.
REQ-006 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port data_i  input  N*SIZE  flat bus; channel k occupies bits [k*SIZE +: SIZE].
REQ-008 SHALL have port valid_i  input  N  per-channel request; bit k valid for channel k.
REQ-009 SHALL have port ready_o  output  N  per-channel accept; bit k high means channel k beat consumed this cycle.
REQ-010 SHALL have port data_o  output  SIZE  registered selected data.
REQ-011 SHALL have port chan_o  output  CW  registered index of channel that sourced data_o.
REQ-012 SHALL have port valid_o  output  1  data_o/chan_o hold a beat.
REQ-013 SHALL have port ready_i  input  1  downstream accepts the beat when valid_o and ready_i both high.

Function
REQ-014 SHALL hold one output register stage; latency from accepted input to valid_o is exactly 1 cycle.
REQ-015 SHALL compute load = ~valid_o | ready_i; a new beat is captured only when load is high.
REQ-016 SHALL assert at most one ready_o bit per cycle, only for the granted channel, and only when load is high; ready_o is combinational from valid_i, pointer, valid_o, ready_i.
REQ-017 SHALL, with RR=0, grant the lowest-index channel with valid_i high.
REQ-018 SHALL, with RR=1, grant the first valid channel searching upward from pointer ptr, wrapping from N-1 to 0.
REQ-019 SHALL, with RR=1, set ptr to (granted index + 1) mod N on each accepted beat; ptr unchanged when no beat accepted.
REQ-020 SHALL, on capture, load data_o with the granted channel slice, chan_o with its index, and set valid_o.
REQ-021 SHALL clear valid_o when load is high and no valid_i bit is set; data_o and chan_o then hold their previous values.
REQ-022 SHALL hold data_o, chan_o, valid_o stable while valid_o high and ready_i low (backpressure); ready_o is all zero then.
REQ-023 SHALL sustain one beat per cycle when ready_i is held high and requests are continuous (simultaneous drain and capture).
REQ-024 SHALL ignore data_i of channels not granted; valid_i may drop without handshake and is not latched.

Reset
REQ-025 SHALL, while rst_i high at a clock edge, set valid_o=0, data_o=0, chan_o=0, ptr=0, hold flag=0.
REQ-026 SHALL drive ready_o all zero while rst_i is high, so no beat is consumed during reset.
REQ-027 SHALL discard any beat held in the output register when reset asserts mid-operation.

Configuration
REQ-028 SHALL, when macro ARB_MUX_HOLD_EN is defined, add port last_i  input  N  per-channel end-of-packet marker.
REQ-029 SHALL, with ARB_MUX_HOLD_EN, lock the grant to the channel of an accepted beat whose last_i bit was low, granting only that channel (others see ready_o=0) until a beat with last_i high is accepted from it.
REQ-030 SHALL, without ARB_MUX_HOLD_EN, have no last_i port and re-arbitrate every accepted beat.

Verification
REQ-031 SHALL cover: reset, then valid_i=4'b0110, ready_i=1, RR=0 -> ready_o=4'b0010 every cycle, chan_o=1 from cycle after first acceptance.
REQ-032 SHALL cover: RR=1, valid_i=4'b1111 held, ready_i=1 -> chan_o sequence 0,1,2,3,0 on consecutive cycles.
REQ-033 SHALL cover: valid_o=1 with data_o=32'hA5A5A5A5, ready_i low 3 cycles -> data_o, chan_o unchanged, ready_o=0 for those cycles; first cycle ready_i=1 accepts next beat.
REQ-034 SHALL cover: RR=1, ptr=3, valid_i=4'b0001 -> grant channel 0 (wrap), ptr becomes 1.
REQ-035 SHALL cover: rst_i asserted while valid_o=1 and valid_i=4'b1111 -> next cycle valid_o=0, data_o=0, ready_o=0 during reset.
REQ-036 SHALL cover, with ARB_MUX_HOLD_EN: channel 2 sends 3 beats, last_i[2] high on third, valid_i=4'b0101 held -> chan_o=2,2,2 then channel 0 granted.
